// File: rtl/uart_tx.sv
// UART transmitter with runtime frame configuration.
//
// Parameters:
//   ClksPerBit  clock cycles per serial bit period (2..65535)
// Ports:
//   clk_i       clock, all logic on the rising edge
//   rst_i       synchronous active-high reset
//   cfg_i       frame config {data_cfg[4:3], stop_cfg[2:1], parity_en[0]}
//                 data bits = data_cfg+5, stop bits = stop_cfg+1 (3 saturates at 3),
//                 parity_en adds one even-parity bit after the data
//   tx_data_i   payload, sent LSB first
//   tx_valid_i  payload offered
//   tx_ready_o  payload can be accepted (IDLE and not in reset)
//   tx_busy_o   frame in progress
//   tx_o        registered serial line, idles high
module uart_tx #(
  parameter int unsigned ClksPerBit = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] cfg_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_o
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] BaudMax = CntW'(ClksPerBit - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic [4:0]      cfg_q, cfg_d;
  logic            tx_q, tx_d;

  logic       accept;
  logic       baud_end;
  logic       parity;
  logic [2:0] data_last_idx;
  logic [2:0] stop_last_idx;
  logic [7:0] data_mask;

  // Frame shape is decoded from the captured config so mid-frame cfg_i changes are harmless.
  assign data_last_idx = {1'b0, cfg_q[4:3]} + 3'd4;
  assign stop_last_idx = (cfg_q[2:1] == 2'd3) ? 3'd2 : {1'b0, cfg_q[2:1]};
  assign data_mask     = 8'hFF >> (3'd7 - data_last_idx);
  assign parity        = ^(data_q & data_mask);

  assign baud_end   = (baud_q == BaudMax);
  assign tx_ready_o = (state_q == StIdle) && !rst_i;
  assign tx_busy_o  = (state_q != StIdle);
  assign accept     = tx_valid_i && tx_ready_o;
  assign tx_o       = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    cfg_d   = cfg_q;
    tx_d    = 1'b1;

    if (state_q != StIdle) begin
      baud_d = baud_end ? '0 : baud_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          data_d  = tx_data_i;
          cfg_d   = cfg_i;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (baud_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == data_last_idx) begin
            bit_d   = '0;
            state_d = cfg_q[0] ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (baud_end) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (baud_end) begin
          if (bit_q == stop_last_idx) begin
            state_d = StIdle;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is derived from the next state so tx_o moves on the same edge as the FSM.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[bit_d];
      StParity: tx_d = parity;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with ClksPerBit=4.
// Expected frames (per-cycle line levels) are pushed to a queue when a payload is offered;
// a monitor pops them when a start bit appears and compares every cycle of the frame.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] cfg_i = '0;
  logic [7:0] tx_data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic       tx_busy_o;
  logic       tx_o;

  int total = 0;
  int bad = 0;

  uart_tx #(
    .ClksPerBit(Cpb)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .cfg_i     (cfg_i),
    .tx_data_i (tx_data_i),
    .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o),
    .tx_busy_o (tx_busy_o),
    .tx_o      (tx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] lv;
    int          n;
  } frame_t;

  frame_t exp_q[$];

  // Reference frame: one level per clock cycle, bit 0 = first cycle after accept.
  function automatic frame_t make_frame(input logic [4:0] cfg, input logic [7:0] data);
    frame_t      f;
    logic [15:0] bits;
    int          nb;
    int          d;
    int          s;
    logic        par;
    d    = int'(cfg[4:3]) + 5;
    s    = (cfg[2:1] == 2'd3) ? 3 : int'(cfg[2:1]) + 1;
    bits = '0;
    nb   = 0;
    par  = 1'b0;
    bits[nb] = 1'b0;
    nb++;
    for (int i = 0; i < d; i++) begin
      bits[nb] = data[i];
      par      = par ^ data[i];
      nb++;
    end
    if (cfg[0]) begin
      bits[nb] = par;
      nb++;
    end
    for (int i = 0; i < s; i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    f.lv = '0;
    f.n  = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        f.lv[f.n] = bits[b];
        f.n++;
      end
    end
    return f;
  endfunction

  // Monitor samples 2 time units after each rising edge, clear of the negedge-driven stimulus.
  frame_t      cur;
  logic [63:0] obs;
  logic [63:0] mask;
  int          idx = 0;
  bit          in_frame = 1'b0;
  bit          stray = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (in_frame && rst_i) begin
      mask = (64'd1 << idx) - 64'd1;
      total++;
      if ((obs & mask) !== (cur.lv & mask)) begin
        bad++;
        $display("FAIL aborted_frame_prefix: got %h want %h over %0d cycles",
                 obs & mask, cur.lv & mask, idx);
      end
      in_frame = 1'b0;
    end else if (in_frame) begin
      obs[idx] = tx_o;
      idx++;
      if (idx == cur.n) begin
        total++;
        if (obs !== cur.lv) begin
          bad++;
          $display("FAIL frame_levels: got %h want %h (%0d cycles)", obs, cur.lv, cur.n);
        end
        in_frame = 1'b0;
      end
    end else if (stray) begin
      if (tx_o === 1'b1) stray = 1'b0;
    end else if (!rst_i && tx_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        stray = 1'b1;
        $display("FAIL unexpected_frame: got start bit want idle line");
      end else begin
        cur      = exp_q.pop_front();
        obs      = '0;
        idx      = 1;
        in_frame = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: got ready=%b want 1 within 1000 cycles", tx_ready_o);
    end
  endtask

  // Offers one payload for a single cycle; returns at the first negedge after accept.
  task automatic start_frame(input logic [4:0] cfg, input logic [7:0] data);
    wait_ready();
    cfg_i      = cfg;
    tx_data_i  = data;
    tx_valid_i = 1'b1;
    exp_q.push_back(make_frame(cfg, data));
    @(negedge clk);
    tx_valid_i = 1'b0;
    total++;
    if (tx_o !== 1'b0 || tx_busy_o !== 1'b1) begin
      bad++;
      $display("FAIL start_latency: got tx=%b busy=%b want tx=0 busy=1", tx_o, tx_busy_o);
    end
  endtask

  // Counts negedges with busy high, starting at the current one.
  task automatic wait_idle(output int n);
    n = 0;
    while (tx_busy_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got tx=%b busy=%b ready=%b want 1 0 0",
               tx_o, tx_busy_o, tx_ready_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (tx_ready_o !== 1'b1 || tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b tx=%b busy=%b want 1 1 0",
               tx_ready_o, tx_o, tx_busy_o);
    end
  endtask

  task automatic test_8n1();
    int n;
    start_frame(5'b11000, 8'hA5);
    wait_idle(n);
    total++;
    if (n != 40 || tx_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL 8n1_busy: got %0d cycles ready=%b want 40 cycles ready=1", n, tx_ready_o);
    end
  endtask

  task automatic test_5e2();
    int n;
    start_frame(5'b00011, 8'hF3);
    wait_idle(n);
    total++;
    if (n != 36) begin
      bad++;
      $display("FAIL 5e2_busy: got %0d want 36", n);
    end
  endtask

  task automatic test_stop_sat();
    int n;
    start_frame(5'b11110, 8'h00);
    wait_idle(n);
    total++;
    if (n != 48) begin
      bad++;
      $display("FAIL stop_sat_busy: got %0d want 48", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    wait_ready();
    cfg_i      = 5'b11000;
    tx_data_i  = 8'h55;
    tx_valid_i = 1'b1;
    exp_q.push_back(make_frame(5'b11000, 8'h55));
    @(negedge clk);
    // Valid stays high while payload and config change under the first frame.
    cfg_i     = 5'b01101;
    tx_data_i = 8'hAA;
    exp_q.push_back(make_frame(5'b01101, 8'hAA));
    wait_idle(n);
    total++;
    if (n != 40) begin
      bad++;
      $display("FAIL b2b_first_busy: got %0d want 40", n);
    end
    total++;
    if (tx_busy_o !== 1'b0 || tx_o !== 1'b1 || tx_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap: got busy=%b tx=%b ready=%b want 0 1 1",
               tx_busy_o, tx_o, tx_ready_o);
    end
    @(negedge clk);
    total++;
    if (tx_busy_o !== 1'b1 || tx_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_start: got busy=%b tx=%b want 1 0", tx_busy_o, tx_o);
    end
    tx_valid_i = 1'b0;
    wait_idle(n);
    total++;
    if (n != 44) begin
      bad++;
      $display("FAIL b2b_second_busy: got %0d want 44", n);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    start_frame(5'b11000, 8'h3C);
    // Data bit 3 spans cycles 17..20 after accept; reset is sampled on the edge ending cycle 18.
    repeat (17) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    total++;
    if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_edge: got tx=%b busy=%b ready=%b want 1 0 0",
               tx_o, tx_busy_o, tx_ready_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (tx_ready_o !== 1'b1 || tx_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_release: got ready=%b tx=%b want 1 1", tx_ready_o, tx_o);
    end
    start_frame(5'b00101, 8'h1B);
    wait_idle(n);
    total++;
    if (n != 40) begin
      bad++;
      $display("FAIL post_reset_busy: got %0d want 40", n);
    end
  endtask

  task automatic test_ignored_valid();
    int n;
    bit seen;
    start_frame(5'b11000, 8'h96);
    repeat (8) @(negedge clk);
    tx_data_i  = 8'hFF;
    cfg_i      = 5'b00000;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    // Nine of the forty busy cycles have already elapsed.
    wait_idle(n);
    total++;
    if (n != 31) begin
      bad++;
      $display("FAIL ignored_valid_busy: got %0d want 31", n);
    end
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (tx_busy_o !== 1'b0 || tx_o !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL ignored_valid_queued: got activity want idle line");
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_5e2();
    test_stop_sat();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_valid();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || in_frame) begin
      bad++;
      $display("FAIL frames_outstanding: got %0d pending in_frame=%b want 0 0",
               exp_q.size(), in_frame);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
